fft_reorder: RTL
================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of each real and imaginary sample.
REQ-002 Parameter N, 16, FFT frame length in points; power of two, N >= 4.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  input sample present.
REQ-006 in_ready  output  1  block can accept an input sample this cycle.
REQ-007 in_re / in_im  input  DATA_WIDTH each  input sample in bit-reversed bin order.
REQ-008 in_last  input  1  producer marks the last sample of a frame.
REQ-009 out_valid  output  1  output sample present.
REQ-010 out_ready  input  1  consumer accepts the output sample.
REQ-011 out_re / out_im  output  DATA_WIDTH each  output sample in natural bin order.
REQ-012 out_last  output  1  marks output bin N-1.
REQ-013 frame_err  output  1  sticky flag for in_last misalignment.

Function
REQ-014 Storage SHALL be two banks (ping-pong) of N complex words each, with a per-bank full flag.
REQ-015 Write side: wbank (1 bit) and wr_cnt (log2 N bits); in_ready = ~full[wbank]; an input handshake is in_valid & in_ready.
REQ-016 On each input handshake, the sample SHALL be written to bank[wbank] at address bitrev(wr_cnt), and wr_cnt SHALL increment.
REQ-017 On the handshake with wr_cnt == N-1: wr_cnt wraps to 0, full[wbank] is set, and wbank toggles.
REQ-018 If in_last on a handshake differs from (wr_cnt == N-1), frame_err SHALL set and hold until reset; the data path is unaffected, and framing follows wr_cnt only.
REQ-019 Read side: rbank and rd_cnt (log2 N bits); the output register set is {out_valid, out_re, out_im, out_last}.
REQ-020 Output load condition: full[rbank] & (~out_valid | out_ready).
  - On load, the output register set takes bank[rbank][rd_cnt], with out_last = (rd_cnt == N-1), and rd_cnt increments.
REQ-021 On a load with rd_cnt == N-1: rd_cnt wraps to 0, full[rbank] clears, and rbank toggles.
REQ-022 out_valid SHALL clear on out_ready & out_valid when no load occurs that cycle.
  - out_* SHALL be held stable while out_valid & ~out_ready.
REQ-023 Latency: out_valid SHALL rise on the second posedge after the handshake edge of input sample N-1 (one cycle in full state), assuming the output register is free.
REQ-024 Throughput: with continuous in_valid and out_ready, the block SHALL sustain one sample per cycle on both sides with no bubbles after the first frame.
REQ-025 Simultaneous set of full[wbank] and clear of full[rbank] in one cycle SHALL both take effect; the two events always target different banks.
REQ-026 Both banks full: in_ready = 0 until the read side frees a bank.
  - in_ready SHALL rise the cycle after the load of bin N-1 from that bank.
REQ-027 The write side SHALL never write a bank whose full flag is set; the read side SHALL never load from a bank whose full flag is clear.

Reset
REQ-028 On rst, the following SHALL reset:
  - full[1:0]=0, wbank=0, rbank=0, wr_cnt=0, rd_cnt=0;
  - out_valid=0, out_last=0, out_re=0, out_im=0, frame_err=0.
REQ-029 Bank contents SHALL NOT be reset.
REQ-030 A rst mid-frame SHALL discard all partial and buffered frames; the first post-reset sample is bin-reversed index 0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-032 Package fft_pkg SHALL hold:
  - the DATA_WIDTH default;
  - the complex sample typedef {re, im};
  - the function bitrev(index, log2N).
REQ-033 The block SHALL be a single module with no sub-module; banks are inferred register or RAM arrays with a combinational read.

Verification (N=8, DATA_WIDTH=16)
REQ-034 Single frame: in_re = 0..7, in_im = 100..107, in_last on the 8th sample, out_ready=1.
  - Required out_re 0,4,2,6,1,5,3,7 and out_im 100,104,102,106,101,105,103,107.
  - out_last on the 8th output; out_valid rises 2 edges after the 8th input handshake.
REQ-035 Back-to-back: 4 frames, continuous in_valid, out_ready=1.
  - in_ready stays 1 throughout; 32 outputs with no gaps, each frame reordered as in REQ-034.
REQ-036 Backpressure: out_ready=0 while 3 frames are offered.
  - in_ready drops after 16 accepted samples; out_re holds 0.
  - After out_ready=1, all 16 buffered samples emerge in order; in_ready rises the cycle after the first frame's bin 7 loads.
REQ-037 Random in_valid/out_ready at 50% over 20 frames: scoreboard matches bitrev order; no loss or duplication.
REQ-038 Misframing: in_last asserted on the 5th sample.
  - frame_err=1 and stays 1; the frame is still emitted as 8 reordered samples.
REQ-039 Reset mid-operation: rst after 5 samples of frame 1, with frame 0 half read.
  - Next cycle: out_valid=0, in_ready=1, frame_err=0.
  - A fresh frame 0..7 yields 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and helpers for the FFT output reorder buffer.
//               Default sample width, complex sample type, bit reversal.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default width of one real or imaginary sample
    localparam int c_data_width_default = 16;

    // Widest index the bit-reversal helper can handle
    localparam int c_bitrev_bits = 16;

    // Complex sample at the default width
    typedef struct packed {
        logic [c_data_width_default-1:0] re;
        logic [c_data_width_default-1:0] im;
    } cplx_t;

    // Reverse the low log2n bits of index; upper result bits are zero
    function automatic logic [c_bitrev_bits-1:0] bitrev(
        input logic [c_bitrev_bits-1:0] index,
        input int                       log2n
    );
        logic [c_bitrev_bits-1:0] rev;
        rev = '0;
        for (int i = 0; i < c_bitrev_bits; i++) begin
            if (i < log2n) begin
                rev = {rev[c_bitrev_bits-2:0], index[i]};
            end
        end
        return rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder
// Description : Ping-pong reorder buffer turning a bit-reversed FFT output
//               stream into natural bin order, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width_default,
    parameter int N          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last,
    output logic                  frame_err
);

    localparam int              c_aw       = $clog2(N);
    localparam logic [c_aw-1:0] c_last_idx = c_aw'(N - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
    } sample_t;

    // Two banks of N samples; the bank index is the outer dimension
    sample_t r_mem [0:1][0:N-1];

    logic [1:0]            r_full;
    logic                  r_wbank;
    logic                  r_rbank;
    logic [c_aw-1:0]       r_wr_cnt;
    logic [c_aw-1:0]       r_rd_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_re;
    logic [DATA_WIDTH-1:0] r_out_im;
    logic                  r_out_last;
    logic                  r_frame_err;

    logic                  w_in_hs;
    logic                  w_wr_wrap;
    logic [c_aw-1:0]       w_wr_addr;
    logic                  w_load;
    logic                  w_rd_wrap;
    logic [1:0]            w_full_nxt;
    sample_t               w_rd_word;

    // A bank is writable only while its full flag is clear
    assign in_ready  = ~r_full[r_wbank];
    assign w_in_hs   = in_valid & in_ready;
    assign w_wr_wrap = w_in_hs & (r_wr_cnt == c_last_idx);
    assign w_wr_addr = c_aw'(bitrev(c_bitrev_bits'(r_wr_cnt), c_aw));

    // Load the output register whenever it is empty or being drained
    assign w_load    = r_full[r_rbank] & (~r_out_valid | out_ready);
    assign w_rd_wrap = w_load & (r_rd_cnt == c_last_idx);
    assign w_rd_word = r_mem[r_rbank][r_rd_cnt];

    // Fill and drain of a bank in the same cycle always hit different banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_wrap) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_rd_wrap) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    // Sample storage, written at the bit-reversed position; never reset
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_mem[r_wbank][w_wr_addr] <= {in_re, in_im};
        end
    end

    // Write-side counters, bank select and framing check
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt    <= '0;
            r_wbank     <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_in_hs) begin
            r_wr_cnt <= w_wr_wrap ? '0 : r_wr_cnt + 1'b1;
            if (w_wr_wrap) begin
                r_wbank <= ~r_wbank;
            end
            if (in_last != (r_wr_cnt == c_last_idx)) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // Bank full flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Read-side counters and bank select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_rbank  <= 1'b0;
        end else if (w_load) begin
            r_rd_cnt <= w_rd_wrap ? '0 : r_rd_cnt + 1'b1;
            if (w_rd_wrap) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    // Output register: load in natural order, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_re    <= w_rd_word.re;
            r_out_im    <= w_rd_word.im;
            r_out_last  <= (r_rd_cnt == c_last_idx);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
